// File: rtl/gpu_pkg.sv
// Shared definitions for the cluster shared-memory responder and its arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpu_pkg;

  // Default geometry of the per-cluster shared memory
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;

  // Responder sequencing: sample/grant, touch the array, signal completion
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } resp_state_e;

  // Encoding of the per-core mem_we bit
  localparam logic MEM_WE_STORE = 1'b1;
  localparam logic MEM_WE_LOAD  = 1'b0;

  // Width of a core index; a single-core cluster still needs one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpu_req_arbiter.sv
// Picks one requesting core per grant; round-robin with SHMEM_RR_ARB_EN, else fixed priority (lowest index).
// Latency: combinational grant; the round-robin pointer advances on the edge where adv is high.
// Backpressure: none; a core keeps requesting until it is granted, nothing is dropped.
module gpu_req_arbiter
  import gpu_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = idx_width(NUM_CORES)
) (
`ifdef SHMEM_RR_ARB_EN
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adv,
`endif
  input  logic [NUM_CORES-1:0] req,
  output logic [NUM_CORES-1:0] gnt,
  output logic [IDX_W-1:0]     gnt_idx
);

  logic [IDX_W-1:0] ptr;

`ifdef SHMEM_RR_ARB_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // Next search start is the core just after the one being granted
  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      ptr_d = (gnt_idx == IDX_W'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Pointer register, cleared to core 0 on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  // Fixed priority is simply a search that always starts at core 0
  assign ptr = '0;
`endif

  logic [IDX_W:0]   cand_sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Circular search from ptr; the first requesting core wins
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand_sum = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (cand_sum >= (IDX_W + 1)'(NUM_CORES)) begin
        cand_sum = cand_sum - (IDX_W + 1)'(NUM_CORES);
      end
      cand = cand_sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/gpu_shared_mem_responder.sv
// Arbitrates core load/store requests onto a byte array, one access at a time; macro SHMEM_RR_ARB_EN selects round-robin.
// Latency: request sampled in IDLE at cycle t, val_data/mem_rdata in t+2; one access per 3 cycles.
// Backpressure: requests are level-held and wait through ACCESS/RESP; only IDLE samples them.
module gpu_shared_mem_responder
  import gpu_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        mem_req,
  input  logic [NUM_CORES-1:0]        mem_we,
  input  logic [NUM_CORES*ADDR_W-1:0] mem_addr,
  input  logic [NUM_CORES*DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0]           mem_rdata,
  output logic [NUM_CORES-1:0]        val_data,
  output logic                        busy
);

  localparam int IDX_W = idx_width(NUM_CORES);
  localparam int DEPTH = 1 << ADDR_W;

  resp_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [NUM_CORES-1:0] val_q, val_d;
  logic                 busy_q, busy_d;

  logic [NUM_CORES-1:0] arb_gnt;
  logic [IDX_W-1:0]     arb_idx;

  // Array is deliberately left out of reset so contents survive a cluster reset
  logic [DATA_W-1:0]    mem_q [0:DEPTH-1];
  logic                 mem_wr_en;
  logic [DATA_W-1:0]    mem_rd_dat;

`ifdef SHMEM_RR_ARB_EN
  logic arb_adv;
  // Pointer moves only when a grant is actually taken in IDLE
  assign arb_adv = (state_q == IDLE) && (|arb_gnt);
`endif

  gpu_req_arbiter #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_arb (
`ifdef SHMEM_RR_ARB_EN
    .clk     (clk),
    .reset   (reset),
    .adv     (arb_adv),
`endif
    .req     (mem_req),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign mem_rd_dat = mem_q[addr_q];
  assign mem_wr_en  = (state_q == ACCESS) && (we_q == MEM_WE_STORE);

  // Next-state and next-output logic; the granted request is captured whole
  // at the grant edge so later changes on the core's inputs are ignored
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    val_d   = '0;
    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          idx_d   = arb_idx;
          we_d    = mem_we[arb_idx];
          addr_d  = mem_addr[arb_idx*ADDR_W +: ADDR_W];
          wdata_d = mem_wdata[arb_idx*DATA_W +: DATA_W];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Loads update the read register; stores leave the last load value visible
        if (we_q == MEM_WE_LOAD) begin
          rdata_d = mem_rd_dat;
        end
        val_d   = NUM_CORES'(1) << idx_q;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM state, captured request and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      we_q    <= MEM_WE_LOAD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      val_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
    end
  end

  // Store commits on the edge that ends ACCESS; an async reset before that edge
  // has already forced IDLE, so the write is dropped
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign mem_rdata = rdata_q;
  assign val_data  = val_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gpu_shared_mem_responder.sv
// Directed self-checking bench for gpu_shared_mem_responder.
// Inputs are driven and outputs sampled on the falling clock edge.
// Arbitration expectations follow whether SHMEM_RR_ARB_EN is defined.
module tb_gpu_shared_mem_responder;

  localparam int NC = 4;
  localparam int AW = 12;
  localparam int DW = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [NC-1:0]  mem_req;
  logic [NC-1:0]  mem_we;
  logic [NC*AW-1:0] mem_addr;
  logic [NC*DW-1:0] mem_wdata;
  logic [DW-1:0]  mem_rdata;
  logic [NC-1:0]  val_data;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  gpu_shared_mem_responder #(
    .NUM_CORES (NC),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .val_data  (val_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_core(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_we[c]             = we;
    mem_addr[c*AW +: AW]  = a;
    mem_wdata[c*DW +: DW] = d;
    mem_req[c]            = 1'b1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    mem_req = '0;
    step();
    step();
    reset = 1'b0;
    check_eq("rst rdata", {24'b0, mem_rdata}, 32'h0);
  endtask

  // One isolated access from core c, starting in an IDLE cycle
  task automatic single(input string tag, input int c, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    set_core(c, we, a, d);
    step();
    check_eq({tag, " busy_t1"}, {31'b0, busy}, 32'h1);
    check_eq({tag, " val_t1"}, {28'b0, val_data}, 32'h0);
    step();
    check_eq({tag, " val_t2"}, {28'b0, val_data}, 32'(1) << c);
    check_eq({tag, " rdata_t2"}, {24'b0, mem_rdata}, {24'b0, exp_rd});
    mem_req[c] = 1'b0;
    step();
    check_eq({tag, " val_t3"}, {28'b0, val_data}, 32'h0);
    check_eq({tag, " busy_t3"}, {31'b0, busy}, 32'h0);
  endtask

  // Wait (bounded) for the next completion pulse from an IDLE cycle with requests already set
  task automatic serve(input string tag, input logic [NC-1:0] exp_val, input logic [DW-1:0] exp_rd,
                       input bit rearm);
    int n;
    logic [NC-1:0] got;
    n = 0;
    do begin
      step();
      n++;
    end while (val_data == '0 && n < 12);
    got = val_data;
    check_eq({tag, " grant"}, {28'b0, got}, {28'b0, exp_val});
    check_eq({tag, " latency"}, n, 2);
    check_eq({tag, " rdata"}, {24'b0, mem_rdata}, {24'b0, exp_rd});
    mem_req = mem_req & ~got;
    step();
    check_eq({tag, " pulse_len"}, {28'b0, val_data}, 32'h0);
    if (rearm) mem_req = mem_req | got;
  endtask

  initial begin
    reset     = 1'b1;
    mem_req   = '0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    step();
    step();
    check_eq("reset val_data", {28'b0, val_data}, 32'h0);
    check_eq("reset rdata", {24'b0, mem_rdata}, 32'h0);
    check_eq("reset busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    step();

    // Store then load on core 1; a later store must not disturb mem_rdata
    single("st123", 1, 1'b1, 12'h123, 8'hA5, 8'h00);
    single("ld123", 1, 1'b0, 12'h123, 8'h00, 8'hA5);
    single("st124", 1, 1'b1, 12'h124, 8'h5B, 8'hA5);

    // Cores 0 and 2 request together; core 0 first, core 2 three cycles later
    single("st010", 0, 1'b1, 12'h010, 8'h11, 8'hA5);
    single("st020", 2, 1'b1, 12'h020, 8'h22, 8'hA5);
    do_reset();
    set_core(0, 1'b0, 12'h010, 8'h00);
    set_core(2, 1'b0, 12'h020, 8'h00);
    serve("dual c0", 4'b0001, 8'h11, 1'b0);
    serve("dual c2", 4'b0100, 8'h22, 1'b0);

    // All four cores requesting continuously
    do_reset();
    for (int c = 0; c < NC; c++) set_core(c, 1'b0, 12'h010, 8'h00);
`ifdef SHMEM_RR_ARB_EN
    serve("all g0", 4'b0001, 8'h11, 1'b1);
    serve("all g1", 4'b0010, 8'h11, 1'b1);
    serve("all g2", 4'b0100, 8'h11, 1'b1);
    serve("all g3", 4'b1000, 8'h11, 1'b1);
    serve("all g4", 4'b0001, 8'h11, 1'b1);
`else
    serve("all g0", 4'b0001, 8'h11, 1'b1);
    serve("all g1", 4'b0001, 8'h11, 1'b1);
    serve("all g2", 4'b0001, 8'h11, 1'b1);
    serve("all g3", 4'b0001, 8'h11, 1'b1);
    serve("all g4", 4'b0001, 8'h11, 1'b1);
`endif
    mem_req = '0;
    step();
    step();
    step();
    check_eq("all drain busy", {31'b0, busy}, 32'h0);

    // Cores 1 and 3 continuous; core 1 stops after its third grant
    do_reset();
    set_core(1, 1'b0, 12'h010, 8'h00);
    set_core(3, 1'b0, 12'h020, 8'h00);
`ifdef SHMEM_RR_ARB_EN
    serve("p13 g0", 4'b0010, 8'h11, 1'b1);
    serve("p13 g1", 4'b1000, 8'h22, 1'b1);
    serve("p13 g2", 4'b0010, 8'h11, 1'b0);
    serve("p13 g3", 4'b1000, 8'h22, 1'b0);
`else
    serve("p13 g0", 4'b0010, 8'h11, 1'b1);
    serve("p13 g1", 4'b0010, 8'h11, 1'b1);
    serve("p13 g2", 4'b0010, 8'h11, 1'b0);
    serve("p13 g3", 4'b1000, 8'h22, 1'b0);
`endif
    step();
    check_eq("p13 idle busy", {31'b0, busy}, 32'h0);

    // Reset during ACCESS of a store: no completion, no write
    single("st_fff_a", 0, 1'b1, 12'hFFF, 8'h77, 8'h22);
    set_core(0, 1'b1, 12'hFFF, 8'h3C);
    step();
    check_eq("rstacc busy_t1", {31'b0, busy}, 32'h1);
    reset   = 1'b1;
    mem_req = '0;
    #1;
    check_eq("rstacc busy_async", {31'b0, busy}, 32'h0);
    check_eq("rstacc val_async", {28'b0, val_data}, 32'h0);
    step();
    check_eq("rstacc val_t2", {28'b0, val_data}, 32'h0);
    reset = 1'b0;
    step();
    check_eq("rstacc val_t3", {28'b0, val_data}, 32'h0);
    check_eq("rstacc busy_t3", {31'b0, busy}, 32'h0);
    single("ld_fff", 0, 1'b0, 12'hFFF, 8'h00, 8'h77);

    // Inputs changed after the grant edge are ignored
    single("st000", 3, 1'b1, 12'h000, 8'h5A, 8'h77);
    single("st001", 3, 1'b1, 12'h001, 8'hC3, 8'h77);
    set_core(2, 1'b0, 12'h000, 8'h00);
    step();
    mem_addr[2*AW +: AW]  = 12'h001;
    mem_we[2]             = 1'b1;
    mem_wdata[2*DW +: DW] = 8'hEE;
    check_eq("late busy_t1", {31'b0, busy}, 32'h1);
    step();
    check_eq("late val_t2", {28'b0, val_data}, 32'h4);
    check_eq("late rdata_t2", {24'b0, mem_rdata}, 32'h5A);
    mem_req[2] = 1'b0;
    step();
    check_eq("late val_t3", {28'b0, val_data}, 32'h0);
    single("ld001", 1, 1'b0, 12'h001, 8'h00, 8'hC3);
    single("ld000", 1, 1'b0, 12'h000, 8'h00, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
